// File: rtl/pipelined_game_renderer_if.sv
// Pixel/game-state bus between the game logic, the video timing and the renderer.
// The master drives the coordinates and the game state, and the slave returns the colour and frame status.
interface pipelined_game_renderer_if #(
  parameter int BALL_COUNT = 2,
  parameter int ROWS       = 6,
  parameter int COLS       = 12
);
  logic [9:0]               X_PIXEL;
  logic [9:0]               Y_PIXEL;
  logic [9:0]               PADDLE_X_PIXEL;
  logic [10*BALL_COUNT-1:0] BALL_X_PIXEL;
  logic [10*BALL_COUNT-1:0] BALL_Y_PIXEL;
  logic [BALL_COUNT-1:0]    BALL_ACTIVE;
  logic [ROWS*COLS-1:0]     BLOCK_STATE;
  logic [7:0]               COLOR;
  logic                     FRAME_DONE;
  logic [7:0]               FRAME_COUNT;

  modport master (
    output X_PIXEL, Y_PIXEL, PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL,
           BALL_ACTIVE, BLOCK_STATE,
    input  COLOR, FRAME_DONE, FRAME_COUNT
  );

  modport slave (
    input  X_PIXEL, Y_PIXEL, PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL,
           BALL_ACTIVE, BLOCK_STATE,
    output COLOR, FRAME_DONE, FRAME_COUNT
  );
endinterface

// File: rtl/pipelined_game_renderer.sv
// Two-stage renderer that draws the housing, the paddle, the balls and the block field from per-frame shadow state.
// Optional feature: define BLOCK_FLASH_EN to make cleared blocks flash for FLASH_FRAMES frames.
module pipelined_game_renderer #(
  parameter int          BALL_COUNT   = 2,
  parameter int          ROWS         = 6,
  parameter int          COLS         = 12,
  parameter int          VISIBLE_W    = 800,
  parameter int          VISIBLE_H    = 600,
  parameter int          BALL_SIZE    = 8,
  parameter int          PADDLE_LEN   = 64,
  parameter logic [63:0] ROW_PALETTE  = 64'h0000_83D0_303F_1E07,
  parameter int          FLASH_FRAMES = 8,
  parameter logic [7:0]  FLASH_COLOR  = 8'hFF
) (
  input logic CLK,
  input logic RESET,
  pipelined_game_renderer_if.slave bus
);
  localparam int          NBLK       = ROWS * COLS;
  localparam logic [9:0]  SNAP_LINE  = 10'(VISIBLE_H);
  localparam logic [10:0] VIS_W      = 11'(VISIBLE_W);
  localparam logic [10:0] VIS_H      = 11'(VISIBLE_H);
  localparam logic [10:0] BALL_EXT   = 11'(BALL_SIZE);
  localparam logic [10:0] PADDLE_EXT = 11'(PADDLE_LEN);
  localparam logic [7:0]  ROWS_L     = 8'(ROWS);
  localparam logic [7:0]  COLS_L     = 8'(COLS);

  logic [9:0]               shadowPaddleX;
  logic [10*BALL_COUNT-1:0] shadowBallX;
  logic [10*BALL_COUNT-1:0] shadowBallY;
  logic [BALL_COUNT-1:0]    shadowBallActive;
  logic [NBLK-1:0]          shadowBlocks;
  logic                     frameDone;
  logic [7:0]               frameCount;
  logic                     snapshot;

  assign snapshot = (bus.X_PIXEL == 10'd0) && (bus.Y_PIXEL == SNAP_LINE);

  // The game state is captured once per frame so that the rendering never sees a half-updated picture.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadowPaddleX    <= '0;
      shadowBallX      <= '0;
      shadowBallY      <= '0;
      shadowBallActive <= '0;
      shadowBlocks     <= '0;
      frameDone        <= 1'b0;
      frameCount       <= 8'd0;
    end else begin
      frameDone <= snapshot;
      if (snapshot) begin
        shadowPaddleX    <= bus.PADDLE_X_PIXEL;
        shadowBallX      <= bus.BALL_X_PIXEL;
        shadowBallY      <= bus.BALL_Y_PIXEL;
        shadowBallActive <= bus.BALL_ACTIVE;
        shadowBlocks     <= bus.BLOCK_STATE;
        frameCount       <= frameCount + 8'd1;
      end
    end
  end

`ifdef BLOCK_FLASH_EN
  localparam int TW = $clog2(FLASH_FRAMES + 1);

  logic [NBLK-1:0] flashMask;
  logic [TW-1:0]   flashTimer;
  logic [NBLK-1:0] clearedBlocks;

  assign clearedBlocks = shadowBlocks & ~bus.BLOCK_STATE;

  // A new clearance restarts the timer for every block that is flashing, and the mask is dropped only when the timer expires.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      flashMask  <= '0;
      flashTimer <= '0;
    end else if (snapshot) begin
      if (|clearedBlocks) begin
        flashMask  <= flashMask | clearedBlocks;
        flashTimer <= TW'(FLASH_FRAMES);
      end else if (flashTimer != '0) begin
        flashTimer <= flashTimer - 1'b1;
        if (flashTimer == TW'(1)) flashMask <= '0;
      end
    end
  end
`endif

  logic [9:0] s1X;
  logic [9:0] s1Y;
  logic [6:0] s1TileX;
  logic [6:0] s1TileY;
  logic       s1Visible;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1X       <= '0;
      s1Y       <= '0;
      s1TileX   <= '0;
      s1TileY   <= '0;
      s1Visible <= 1'b0;
    end else begin
      s1X       <= bus.X_PIXEL;
      s1Y       <= bus.Y_PIXEL;
      s1TileX   <= bus.X_PIXEL[9:3];
      s1TileY   <= bus.Y_PIXEL[9:3];
      s1Visible <= ({1'b0, bus.X_PIXEL} < VIS_W) && ({1'b0, bus.Y_PIXEL} < VIS_H);
    end
  end

  logic [10:0]           pixX;
  logic [10:0]           pixY;
  logic [BALL_COUNT-1:0] ballHitVec;
  logic [10:0]           paddleLeft;
  logic                  paddleHit;
  logic                  housingHit;

  assign pixX = {1'b0, s1X};
  assign pixY = {1'b0, s1Y};

  // Extents are summed in 11 bits so that an object near X=1023 does not wrap back onto column 0.
  for (genvar i = 0; i < BALL_COUNT; i++) begin : gBall
    logic [10:0] ballLeft;
    logic [10:0] ballTop;
    assign ballLeft      = {1'b0, shadowBallX[10*i +: 10]};
    assign ballTop       = {1'b0, shadowBallY[10*i +: 10]};
    assign ballHitVec[i] = shadowBallActive[i]
                           && (pixX >= ballLeft) && (pixX < ballLeft + BALL_EXT)
                           && (pixY >= ballTop)  && (pixY < ballTop + BALL_EXT);
  end

  assign paddleLeft = {1'b0, shadowPaddleX};
  assign paddleHit  = (s1TileY == 7'd70) && (pixX >= paddleLeft) && (pixX < paddleLeft + PADDLE_EXT);
  assign housingHit = ((s1TileY == 7'd2) && (s1TileX >= 7'd1) && (s1TileX <= 7'd98))
                      || (((s1TileX == 7'd1) || (s1TileX == 7'd98)) && (s1TileY >= 7'd2));

  // Tiles left of or above the block origin wrap to large values, which the same range checks reject.
  logic [7:0]   blkCol;
  logic [7:0]   blkRow;
  logic [7:0]   blkIndex;
  logic         blkInField;
  logic [255:0] blocksWide;
  logic         blockPresent;
  logic [7:0]   rowColor;

  assign blkCol       = 8'({1'b0, s1TileX} - 8'd2) >> 3;
  assign blkRow       = 8'({1'b0, s1TileY} - 8'd4) >> 1;
  assign blkInField   = (blkCol < COLS_L) && (blkRow < ROWS_L);
  assign blkIndex     = {5'd0, blkRow[2:0]} * COLS_L + {4'd0, blkCol[3:0]};
  assign blocksWide   = {{(256-NBLK){1'b0}}, shadowBlocks};
  assign blockPresent = blkInField && blocksWide[blkIndex];
  assign rowColor     = ROW_PALETTE[{blkRow[2:0], 3'b000} +: 8];

`ifdef BLOCK_FLASH_EN
  logic [255:0] flashWide;
  logic         flashHit;
  assign flashWide = {{(256-NBLK){1'b0}}, flashMask};
  assign flashHit  = blkInField && flashWide[blkIndex];
`endif

  logic [7:0] nextColor;
  logic [7:0] colorReg;

  // The first matching layer wins, with the balls on top and the background at the bottom.
  always_comb begin
    nextColor = 8'h00;
    if (!s1Visible)          nextColor = 8'h00;
    else if (|ballHitVec)    nextColor = 8'hFF;
    else if (paddleHit)      nextColor = 8'hFF;
    else if (housingHit)     nextColor = 8'hFF;
`ifdef BLOCK_FLASH_EN
    else if (flashHit)       nextColor = FLASH_COLOR;
`endif
    else if (blockPresent)   nextColor = rowColor;
  end

  always_ff @(posedge CLK) begin
    if (RESET) colorReg <= 8'h00;
    else       colorReg <= nextColor;
  end

  assign bus.COLOR       = colorReg;
  assign bus.FRAME_DONE  = frameDone;
  assign bus.FRAME_COUNT = frameCount;
endmodule

// File: tb/tb_pipelined_game_renderer.sv
// Directed bench for pipelined_game_renderer with hand-computed pixel colours and frame counters.
// Define BLOCK_FLASH_EN together with the RTL to exercise the flashing of cleared blocks.
module tb_pipelined_game_renderer;
  logic CLK = 1'b0;
  logic RESET;
  int   checkCount = 0;
  int   passCount  = 0;
  int   expFrames  = 0;

  always #5 CLK = ~CLK;

  pipelined_game_renderer_if #(.BALL_COUNT(2), .ROWS(6), .COLS(12)) bus();

  pipelined_game_renderer #(.BALL_COUNT(2), .ROWS(6), .COLS(12)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y);
    bus.X_PIXEL = x;
    bus.Y_PIXEL = y;
    tick();
  endtask

  // The colour for a pixel appears after the second clock edge.
  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y, input logic [7:0] exp);
    applyStimulus(x, y);
    tick();
    checkOutput(tag, 32'(bus.COLOR), 32'(exp));
  endtask

  task automatic doSnapshot();
    applyStimulus(10'd0, 10'd600);
    expFrames = (expFrames + 1) % 256;
    bus.X_PIXEL = 10'd1;
  endtask

  initial begin
    bus.X_PIXEL        = '0;
    bus.Y_PIXEL        = '0;
    bus.PADDLE_X_PIXEL = '0;
    bus.BALL_X_PIXEL   = '0;
    bus.BALL_Y_PIXEL   = '0;
    bus.BALL_ACTIVE    = '0;
    bus.BLOCK_STATE    = '0;
    RESET = 1'b1;
    tick();
    tick();
    checkOutput("resetColor", 32'(bus.COLOR), 32'h0);
    checkOutput("resetDone", 32'(bus.FRAME_DONE), 32'h0);
    checkOutput("resetCount", 32'(bus.FRAME_COUNT), 32'h0);
    RESET = 1'b0;

    $display("[TB] ceiling line stream");
    bus.Y_PIXEL = 10'd16;
    for (int i = 0; i <= 800; i++) begin
      bus.X_PIXEL = (i < 800) ? 10'(i) : 10'd0;
      tick();
      if (i >= 1)
        checkOutput($sformatf("stream x=%0d", i - 1), 32'(bus.COLOR),
                    ((i - 1) >= 8 && (i - 1) <= 791) ? 32'hFF : 32'h0);
    end
    checkOutput("streamCount", 32'(bus.FRAME_COUNT), 32'h0);
    probe("wallLeft", 10'd8, 10'd100, 8'hFF);
    probe("wallRight", 10'd784, 10'd100, 8'hFF);
    probe("aboveCeiling", 10'd100, 10'd8, 8'h00);

    $display("[TB] block field");
    bus.BLOCK_STATE = '1;
    doSnapshot();
    probe("blkRow0", 10'd40, 10'd32, 8'h07);
    probe("blkRow1", 10'd40, 10'd48, 8'h1E);
    probe("blkRow5", 10'd40, 10'd112, 8'h83);
    probe("blkRow6", 10'd40, 10'd128, 8'h00);
    probe("blkCol0Left", 10'd16, 10'd32, 8'h07);
    probe("blkWallOver", 10'd15, 10'd32, 8'hFF);
    probe("blkCol11", 10'd783, 10'd32, 8'h07);
    probe("blkCol12", 10'd792, 10'd32, 8'h00);

    $display("[TB] snapshot isolation");
    bus.BALL_X_PIXEL = {10'd500, 10'd200};
    bus.BALL_Y_PIXEL = {10'd300, 10'd300};
    bus.BALL_ACTIVE  = 2'b01;
    probe("ballBeforeSnap", 10'd200, 10'd300, 8'h00);
    doSnapshot();
    checkOutput("doneHigh", 32'(bus.FRAME_DONE), 32'h1);
    checkOutput("countAfterSnap", 32'(bus.FRAME_COUNT), 32'(expFrames));
    applyStimulus(10'd1, 10'd600);
    checkOutput("doneLow", 32'(bus.FRAME_DONE), 32'h0);
    probe("ballOrigin", 10'd200, 10'd300, 8'hFF);
    probe("ballCorner", 10'd207, 10'd307, 8'hFF);
    probe("ballRightOut", 10'd208, 10'd300, 8'h00);
    probe("ballLeftOut", 10'd199, 10'd300, 8'h00);
    bus.BALL_X_PIXEL = {10'd500, 10'd400};
    probe("ballOldPos", 10'd200, 10'd300, 8'hFF);
    probe("ballNewPosHidden", 10'd400, 10'd300, 8'h00);
    doSnapshot();
    probe("ballMovedOld", 10'd200, 10'd300, 8'h00);
    probe("ballMovedNew", 10'd400, 10'd300, 8'hFF);

    $display("[TB] visible window");
    bus.BALL_Y_PIXEL   = {10'd300, 10'd598};
    bus.PADDLE_X_PIXEL = 10'd790;
    doSnapshot();
    probe("ballVisible", 10'd400, 10'd599, 8'hFF);
    probe("ballBelowH", 10'd400, 10'd601, 8'h00);
    probe("paddleVisible", 10'd795, 10'd565, 8'hFF);
    probe("paddleBeyondW", 10'd800, 10'd565, 8'h00);

    $display("[TB] balls and paddle");
    bus.PADDLE_X_PIXEL = 10'd100;
    bus.BALL_X_PIXEL   = {10'd500, 10'd300};
    bus.BALL_Y_PIXEL   = {10'd560, 10'd560};
    bus.BALL_ACTIVE    = 2'b01;
    doSnapshot();
    probe("ball0Drawn", 10'd303, 10'd563, 8'hFF);
    probe("ball1Inactive", 10'd503, 10'd563, 8'h00);
    probe("paddleLeft", 10'd100, 10'd565, 8'hFF);
    probe("paddleLast", 10'd163, 10'd565, 8'hFF);
    probe("paddleEnd", 10'd164, 10'd565, 8'h00);
    probe("paddleBefore", 10'd99, 10'd565, 8'h00);
    bus.BALL_X_PIXEL = {10'd124, 10'd120};
    bus.BALL_Y_PIXEL = {10'd558, 10'd556};
    bus.BALL_ACTIVE  = 2'b11;
    doSnapshot();
    probe("overlapAll", 10'd125, 10'd560, 8'hFF);
    probe("ball1Only", 10'd130, 10'd559, 8'hFF);
    probe("ball0Only", 10'd121, 10'd557, 8'hFF);
    probe("pastBall1", 10'd132, 10'd559, 8'h00);
    bus.BALL_X_PIXEL   = {10'd500, 10'd1020};
    bus.BALL_Y_PIXEL   = {10'd300, 10'd300};
    bus.BALL_ACTIVE    = 2'b01;
    bus.PADDLE_X_PIXEL = 10'd1020;
    doSnapshot();
    probe("ballNoWrap0", 10'd0, 10'd300, 8'h00);
    probe("ballNoWrap3", 10'd3, 10'd300, 8'h00);
    probe("paddleNoWrap0", 10'd0, 10'd565, 8'h00);
    probe("paddleNoWrap5", 10'd5, 10'd565, 8'h00);

    $display("[TB] reset on snapshot edge");
    bus.X_PIXEL = 10'd0;
    bus.Y_PIXEL = 10'd600;
    RESET = 1'b1;
    tick();
    checkOutput("rstSnapDone", 32'(bus.FRAME_DONE), 32'h0);
    checkOutput("rstSnapCount", 32'(bus.FRAME_COUNT), 32'h0);
    checkOutput("rstSnapColor", 32'(bus.COLOR), 32'h0);
    RESET = 1'b0;
    expFrames = 0;
    applyStimulus(10'd40, 10'd32);
    checkOutput("rstFirstOut", 32'(bus.COLOR), 32'h0);
    tick();
    checkOutput("rstShadowBlocks", 32'(bus.COLOR), 32'h0);
    checkOutput("rstCountHeld", 32'(bus.FRAME_COUNT), 32'h0);

    $display("[TB] frame counter wrap");
    bus.X_PIXEL = 10'd0;
    bus.Y_PIXEL = 10'd600;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 255) checkOutput("count255", 32'(bus.FRAME_COUNT), 32'd255);
    end
    checkOutput("countWrap", 32'(bus.FRAME_COUNT), 32'd0);
    bus.X_PIXEL = 10'd1;
    expFrames = 0;

    $display("[TB] cleared block");
    bus.BLOCK_STATE = '1;
    doSnapshot();
    probe("blkBeforeClear", 10'd40, 10'd32, 8'h07);
    bus.BLOCK_STATE[0] = 1'b0;
`ifdef BLOCK_FLASH_EN
    for (int k = 1; k <= 8; k++) begin
      doSnapshot();
      probe($sformatf("flash%0d", k), 10'd40, 10'd32, 8'hFF);
    end
    doSnapshot();
    probe("flashOver", 10'd40, 10'd32, 8'h00);
`else
    doSnapshot();
    probe("clearedGone", 10'd40, 10'd32, 8'h00);
`endif
    probe("neighbourKept", 10'd120, 10'd32, 8'h07);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
